// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between 16 requesters and the round-robin arbiter.
interface rr_arbiter16_if;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        preempt;

  modport master (output req, input grant, grant_idx, grant_valid, preempt);
  modport slave  (input req, output grant, grant_idx, grant_valid, preempt);
endinterface

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with registered one-hot grant, mux-select index
// and optional forced handoff after MAX_HOLD consecutive grant cycles.
module rr_arbiter16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          reset,
  rr_arbiter16_if.slave bus
);
  localparam int         N        = 16;
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;

  state_t       state;
  logic [3:0]   ptr, gidx;
  logic [7:0]   hold_cnt;
  logic [N-1:0] gnt;
  logic         gvld, pre;

  // Returns {found, idx}: first set bit of cand at or after start, wrapping.
  function automatic logic [4:0] pick(input logic [N-1:0] cand, input logic [3:0] start);
    logic [4:0] r;
    logic [3:0] i;
    r = '0;
    for (int k = N-1; k >= 0; k--) begin
      i = start + 4'(k);
      if (cand[i]) r = {1'b1, i};
    end
    return r;
  endfunction

  logic [N-1:0] others;
  logic [4:0]   pa, po;
  logic         own_req, at_limit;

  always_comb begin
    others   = bus.req & ~gnt;
    own_req  = bus.req[gidx];
    pa       = pick(bus.req, ptr);
    po       = pick(others, gidx + 4'd1);
    // >= so an owner that ran past the limit alone still yields once contention appears
    at_limit = (HOLD_LIM != 8'd0) && (hold_cnt >= HOLD_LIM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      gidx     <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gvld     <= 1'b0;
      pre      <= 1'b0;
    end else begin
      pre <= 1'b0;
      case (state)
        IDLE: begin
          if (pa[4]) begin
            state    <= GRANT;
            gidx     <= pa[3:0];
            gnt      <= 16'd1 << pa[3:0];
            gvld     <= 1'b1;
            hold_cnt <= 8'd1;
            ptr      <= pa[3:0] + 4'd1;
          end
        end
        GRANT: begin
          if (own_req && !(at_limit && po[4])) begin
            if (hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'd1;
          end else if (po[4]) begin
            // Release or forced handoff straight to the next requester, no bubble
            gidx     <= po[3:0];
            gnt      <= 16'd1 << po[3:0];
            hold_cnt <= 8'd1;
            ptr      <= po[3:0] + 4'd1;
            pre      <= own_req;
          end else begin
            state    <= IDLE;
            gnt      <= '0;
            gvld     <= 1'b0;
            hold_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          gnt      <= '0;
          gvld     <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.grant       = gnt;
  assign bus.grant_idx   = gidx;
  assign bus.grant_valid = gvld;
  assign bus.preempt     = pre;
endmodule

// File: tb/tb_rr_arbiter16.sv
// Random + directed bench for rr_arbiter16 at MAX_HOLD 8, 2 and 0, checked
// against an owner/pointer reference model.
module tb_rr_arbiter16;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  rr_arbiter16_if if8 ();
  rr_arbiter16_if if2 ();
  rr_arbiter16_if if0 ();
  assign if8.req = req;
  assign if2.req = req;
  assign if0.req = req;

  rr_arbiter16 #(.MAX_HOLD(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));
  rr_arbiter16 #(.MAX_HOLD(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));
  rr_arbiter16 #(.MAX_HOLD(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));

  typedef struct {
    int owner;  // -1 when idle
    int last;
    int ptr;
    int cnt;
    bit pre;
  } mdl_t;

  mdl_t mdl[3];
  int   mh[3] = '{8, 2, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rrpick(input logic [15:0] r, input int start);
    for (int k = 0; k < 16; k++)
      if (r[(start + k) % 16]) return (start + k) % 16;
    return -1;
  endfunction

  function automatic mdl_t step(input mdl_t m, input int lim, input logic [15:0] r, input logic rs);
    logic [15:0] oth;
    bit          mine;
    int          nxt;
    if (rs) begin
      m.owner = -1; m.last = 0; m.ptr = 0; m.cnt = 0; m.pre = 0;
      return m;
    end
    m.pre = 0;
    if (m.owner < 0) begin
      nxt = rrpick(r, m.ptr);
      if (nxt >= 0) begin
        m.owner = nxt; m.last = nxt; m.cnt = 1; m.ptr = (nxt + 1) % 16;
      end
      return m;
    end
    oth = r;
    oth[m.owner] = 1'b0;
    mine = r[m.owner];
    if (mine && !(lim != 0 && m.cnt >= lim && oth != 0)) begin
      if (m.cnt < 255) m.cnt++;
    end else if (oth != 0) begin
      nxt = rrpick(oth, (m.owner + 1) % 16);
      m.pre = mine; m.owner = nxt; m.last = nxt; m.cnt = 1; m.ptr = (nxt + 1) % 16;
    end else begin
      m.owner = -1; m.cnt = 0;
    end
    return m;
  endfunction

  task automatic cmp_one(input string nm, input mdl_t m, input logic [15:0] g,
                         input logic [3:0] ix, input logic v, input logic p);
    logic [15:0] eg;
    eg = (m.owner >= 0) ? (16'd1 << m.owner) : 16'd0;
    chk({nm, ".grant"}, 32'(g), 32'(eg));
    chk({nm, ".idx"},   32'(ix), 32'(m.last));
    chk({nm, ".valid"}, 32'(v), 32'(m.owner >= 0));
    chk({nm, ".preempt"}, 32'(p), 32'(m.pre));
  endtask

  // Drive at negedge, predict, then compare at the following negedge.
  task automatic cyc(input logic [15:0] r, input logic rs);
    req = r;
    reset = rs;
    for (int i = 0; i < 3; i++) mdl[i] = step(mdl[i], mh[i], r, rs);
    @(negedge clk);
    cmp_one("m8", mdl[0], if8.grant, if8.grant_idx, if8.grant_valid, if8.preempt);
    cmp_one("m2", mdl[1], if2.grant, if2.grant_idx, if2.grant_valid, if2.preempt);
    cmp_one("m0", mdl[2], if0.grant, if0.grant_idx, if0.grant_valid, if0.preempt);
  endtask

  logic [15:0] r;

  initial begin
    req = '0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) mdl[i] = step(mdl[i], mh[i], 16'h0, 1'b1);
    @(negedge clk);

    // Reset held with all requesting
    for (int k = 0; k < 3; k++) cyc(16'hFFFF, 1'b1);
    chk("rst.grant", 32'(if8.grant), 32'h0);
    chk("rst.idx", 32'(if8.grant_idx), 32'h0);
    chk("rst.valid", 32'(if8.grant_valid), 32'h0);

    // Single requester: 1-cycle latency, idle keeps last index
    cyc(16'h0000, 1'b0);
    cyc(16'h0020, 1'b0);
    chk("t2.grant", 32'(if8.grant), 32'h0020);
    chk("t2.idx", 32'(if8.grant_idx), 32'd5);
    for (int k = 0; k < 3; k++) cyc(16'h0020, 1'b0);
    cyc(16'h0000, 1'b0);
    chk("t2.rel_valid", 32'(if8.grant_valid), 32'h0);
    chk("t2.rel_idx", 32'(if8.grant_idx), 32'd5);

    // MAX_HOLD=2 rotation with everybody requesting
    cyc(16'h0000, 1'b1);
    for (int k = 0; k < 34; k++) begin
      cyc(16'hFFFF, 1'b0);
      chk("t3.idx", 32'(if2.grant_idx), 32'((k / 2) % 16));
      chk("t3.preempt", 32'(if2.preempt), 32'(k > 0 && k % 2 == 0));
    end

    // Release handoff order
    cyc(16'h0000, 1'b1);
    cyc(16'h0008, 1'b0);
    chk("t4.idx3", 32'(if8.grant_idx), 32'd3);
    cyc(16'h020A, 1'b0);
    cyc(16'h0202, 1'b0);
    chk("t4.idx9", 32'(if8.grant_idx), 32'd9);
    chk("t4.nopre", 32'(if8.preempt), 32'd0);
    cyc(16'h0002, 1'b0);
    chk("t4.idx1", 32'(if8.grant_idx), 32'd1);

    // Reset pulse mid-grant
    cyc(16'h0000, 1'b1);
    cyc(16'h0080, 1'b0);
    chk("t5.idx7", 32'(if8.grant_idx), 32'd7);
    cyc(16'hFFFF, 1'b1);
    chk("t5.grant", 32'(if8.grant), 32'h0);
    chk("t5.idx", 32'(if8.grant_idx), 32'd0);
    cyc(16'hFFFF, 1'b0);
    chk("t5.regrant", 32'(if8.grant_idx), 32'd0);

    // Unlimited hold
    cyc(16'h0000, 1'b1);
    cyc(16'h0010, 1'b0);
    for (int k = 0; k < 300; k++) begin
      cyc(16'h0410, 1'b0);
      if (if0.grant_idx != 4'd4 || if0.preempt) chk("t6.hold", {if0.preempt, 27'd0, if0.grant_idx}, 32'd4);
    end
    chk("t6.held", 32'(if0.grant), 32'h0010);
    cyc(16'h0400, 1'b0);
    chk("t6.idx10", 32'(if0.grant_idx), 32'd10);

    // Random traffic; requests change occasionally so holds run long
    r = '0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(3))
          0: r = 16'($urandom);
          1: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
          2: r = 16'd1 << $urandom_range(15);
          default: r = '0;
        endcase
      end
      cyc(r, $urandom_range(99) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
